// File: rtl/data_memory_unit_if.sv
// MEM-stage data memory request/response bundle.
// Master issues loads/stores; slave returns registered load data.
interface data_memory_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              error;

  modport master (
    output read, write, address, size,
    output unsigned_ld, data,
    input  read_data, read_valid, error
  );

  modport slave (
    input  read, write, address, size,
    input  unsigned_ld, data,
    output read_data, read_valid, error
  );
endinterface

// File: rtl/data_memory_unit.sv
// Byte-addressed MEM-stage data memory with byte/half/word access,
// load extension, 1-cycle registered reads and request checking.
module data_memory_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_unit_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     idx;
  logic [1:0]        lane;
  logic              sz_b;
  logic              sz_h;
  logic              sz_w;
  logic              oor;
  logic              misal;
  logic              bad;
  logic              req;
  logic              we;
  logic              re;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;

  always_comb begin
    idx     = bus.address[IW+1:2];
    lane    = bus.address[1:0];
    sz_b    = bus.size == 2'b00;
    sz_h    = bus.size == 2'b01;
    sz_w    = bus.size == 2'b10;
    oor     = |bus.address[ADDR_W-1:IW+2];
    misal   = (sz_h & lane[0]) | (sz_w & |lane);
    bad     = (bus.read & bus.write) | (bus.size == 2'b11)
            | misal | oor;
    req     = bus.read | bus.write;
    we      = bus.write & ~bus.read & ~bad;
    re      = bus.read & ~bus.write & ~bad;
    word    = mem[idx];
    shifted = word >> {lane, 3'b000};
    be      = 4'b0000;
    wdata   = bus.data;
    ext     = word;
    unique case (1'b1)
      sz_b: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.data[7:0]}};
        ext   = {{24{shifted[7] & ~bus.unsigned_ld}},
                 shifted[7:0]};
      end
      sz_h: begin
        be    = 4'b0011 << lane;
        wdata = {2{bus.data[15:0]}};
        ext   = {{16{shifted[15] & ~bus.unsigned_ld}},
                 shifted[15:0]};
      end
      sz_w: begin
        be    = 4'b1111;
        wdata = bus.data;
        ext   = word;
      end
      default: begin
        be    = 4'b0000;
        wdata = bus.data;
        ext   = word;
      end
    endcase
  end

  // Array has no reset; rst_n only gates stores.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.read_data  <= '0;
      bus.read_valid <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.read_valid <= re;
      bus.error      <= req & bad;
      if (re) bus.read_data <= ext;
    end
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: vector table fed
// through a scoreboard queue, plus reset corner sequences.
module tb_data_memory_unit;
  logic clk;
  logic rst_n;

  data_memory_unit_if bus ();

  data_memory_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] d;
    bit          ev;
    bit          ee;
    logic [31:0] erd;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
    string n, bit rd, bit wr, logic [31:0] a,
    logic [1:0] sz, bit u, logic [31:0] d,
    bit ev, bit ee, logic [31:0] erd);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.addr = a;
    v.sz = sz; v.uns = u; v.d = d;
    v.ev = ev; v.ee = ee; v.erd = erd;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.read        = v.rd;
    bus.write       = v.wr;
    bus.address     = v.addr;
    bus.size        = v.sz;
    bus.unsigned_ld = v.uns;
    bus.data        = v.d;
  endtask

  task automatic check_pending();
    vec_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({e.name, " valid"}, {31'd0, bus.read_valid},
        {31'd0, e.ev});
    chk({e.name, " error"}, {31'd0, bus.error},
        {31'd0, e.ee});
    chk({e.name, " rdata"}, bus.read_data, e.erd);
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    check_pending();
    drive(v);
    exp_q.push_back(v);
  endtask

  task automatic idle();
    @(negedge clk);
    check_pending();
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    tv.push_back(mk("SW 10",    0,1,32'h10, 2,0,32'h8000_00F0, 0,0,32'h0));
    tv.push_back(mk("LW 10",    1,0,32'h10, 2,0,0, 1,0,32'h8000_00F0));
    tv.push_back(mk("LB 10",    1,0,32'h10, 0,0,0, 1,0,32'hFFFF_FFF0));
    tv.push_back(mk("LBU 10",   1,0,32'h10, 0,1,0, 1,0,32'h0000_00F0));
    tv.push_back(mk("LH 12",    1,0,32'h12, 1,0,0, 1,0,32'hFFFF_8000));
    tv.push_back(mk("LHU 12",   1,0,32'h12, 1,1,0, 1,0,32'h0000_8000));
    tv.push_back(mk("SB 11",    0,1,32'h11, 0,0,32'h1234_56AB, 0,0,32'h0000_8000));
    tv.push_back(mk("LW 10b",   1,0,32'h10, 2,0,0, 1,0,32'h8000_ABF0));
    tv.push_back(mk("LW 12 mis",1,0,32'h12, 2,0,0, 0,1,32'h8000_ABF0));
    tv.push_back(mk("LW 11 mis",1,0,32'h11, 2,0,0, 0,1,32'h8000_ABF0));
    tv.push_back(mk("LH 11 mis",1,0,32'h11, 1,0,0, 0,1,32'h8000_ABF0));
    tv.push_back(mk("SH 13 mis",0,1,32'h13, 1,0,32'h0000_FFFF, 0,1,32'h8000_ABF0));
    tv.push_back(mk("RW both",  1,1,32'h10, 2,0,32'h0, 0,1,32'h8000_ABF0));
    tv.push_back(mk("size 11",  1,0,32'h10, 3,0,0, 0,1,32'h8000_ABF0));
    tv.push_back(mk("SW oor",   0,1,32'h410,2,0,32'hDEAD_BEEF, 0,1,32'h8000_ABF0));
    tv.push_back(mk("LW oor",   1,0,32'h400,2,0,0, 0,1,32'h8000_ABF0));
    tv.push_back(mk("LW 10c",   1,0,32'h10, 2,0,0, 1,0,32'h8000_ABF0));
    tv.push_back(mk("idle1",    0,0,32'h10, 2,0,0, 0,0,32'h8000_ABF0));
    tv.push_back(mk("LH 10",    1,0,32'h10, 1,0,0, 1,0,32'hFFFF_ABF0));
    tv.push_back(mk("LB 11",    1,0,32'h11, 0,0,0, 1,0,32'hFFFF_FFAB));
    tv.push_back(mk("LHU 10",   1,0,32'h10, 1,1,0, 1,0,32'h0000_ABF0));
    tv.push_back(mk("LB 13",    1,0,32'h13, 0,0,0, 1,0,32'hFFFF_FF80));
    tv.push_back(mk("LBU 12",   1,0,32'h12, 0,1,0, 1,0,32'h0000_0000));
    tv.push_back(mk("SH 12",    0,1,32'h12, 1,0,32'h0000_1234, 0,0,32'h0));
    tv.push_back(mk("LW 10 raw",1,0,32'h10, 2,0,0, 1,0,32'h1234_ABF0));
    tv.push_back(mk("SB 3FF",   0,1,32'h3FF,0,0,32'h0000_005A, 0,0,32'h1234_ABF0));
    tv.push_back(mk("LBU 3FF",  1,0,32'h3FF,0,1,0, 1,0,32'h0000_005A));
    tv.push_back(mk("LB 3FF",   1,0,32'h3FF,0,0,0, 1,0,32'h0000_005A));
    tv.push_back(mk("SW 0",     0,1,32'h0,  2,0,32'h1111_1111, 0,0,32'h0000_005A));
    tv.push_back(mk("SW 4",     0,1,32'h4,  2,0,32'h2222_2222, 0,0,32'h0000_005A));
    tv.push_back(mk("SW 8",     0,1,32'h8,  2,0,32'h3333_3333, 0,0,32'h0000_005A));
    tv.push_back(mk("LW 0",     1,0,32'h0,  2,0,0, 1,0,32'h1111_1111));
    tv.push_back(mk("LW 4",     1,0,32'h4,  2,0,0, 1,0,32'h2222_2222));
    tv.push_back(mk("LW 8",     1,0,32'h8,  2,0,0, 1,0,32'h3333_3333));
    tv.push_back(mk("idle2",    0,0,32'h0,  2,0,0, 0,0,32'h3333_3333));

    rst_n = 1'b0;
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("reset rdata", bus.read_data, 32'h0);
    chk("reset valid", {31'd0, bus.read_valid}, 32'h0);
    chk("reset error", {31'd0, bus.error}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) step(tv[i]);
    idle();

    // Assert reset mid-cycle with a store on the bus.
    @(negedge clk);
    check_pending();
    drive(mk("sw drop", 0, 1, 32'h0, 2, 0, 32'h9999_9999,
             0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("async rst rdata", bus.read_data, 32'h0);
    chk("async rst valid", {31'd0, bus.read_valid}, 32'h0);
    chk("async rst error", {31'd0, bus.error}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    step(mk("LW 0 post rst", 1,0,32'h0,2,0,0, 1,0,32'h1111_1111));
    step(mk("idle3", 0,0,32'h0,2,0,0, 0,0,32'h1111_1111));
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
